// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and packed-port slicing helper
// for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_WORDS      = 32;

    // Low bit offset of slice `port` in a vector of `width`-bit slices.
    function automatic int rf_slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: write, reserve and read-port bundle of the register file.
// The master side drives the control unit's requests. The slave side is the register file.
interface regfile_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SELECT_SIZE = 5,
    parameter int READ_PORTS  = 2
);
    logic                              reg_we_i;
    logic [SELECT_SIZE-1:0]            reg_dst_i;
    logic [DATA_WIDTH-1:0]             data_i;
    logic                              rsv_i;
    logic [SELECT_SIZE-1:0]            reg_rsv_i;
    logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i;
    logic [READ_PORTS*DATA_WIDTH-1:0]  src_o;
    logic [READ_PORTS-1:0]             pending_o;
    logic                              ready_o;

    modport master (
        output reg_we_i, reg_dst_i, data_i, rsv_i, reg_rsv_i, reg_src_i,
        input  src_o, pending_o, ready_o
    );

    modport slave (
        input  reg_we_i, reg_dst_i, data_i, rsv_i, reg_rsv_i, reg_src_i,
        output src_o, pending_o, ready_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one write-pending bit per register.
// A reserve sets a bit and a write clears it. If both hit the same index in one cycle, the reserve wins.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write hides the pending bit of the register it writes.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WORDS       = RF_WORDS,
    parameter int SELECT_SIZE = $clog2(WORDS),
    parameter int READ_PORTS  = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_en,
    input  logic [SELECT_SIZE-1:0]            wr_idx,
    input  logic                              rsv_en,
    input  logic [SELECT_SIZE-1:0]            rsv_idx,
    input  logic [READ_PORTS*SELECT_SIZE-1:0] src_idx,
    output logic [READ_PORTS-1:0]             pending
);
    logic [WORDS-1:0]       busy_r;
    logic [WORDS-1:0]       busy_n_s;
    logic [READ_PORTS-1:0]  pending_s;
    logic [SELECT_SIZE-1:0] idx_s;

    // Next pending vector: clear on write, then set on reserve.
    always_comb begin
        busy_n_s = busy_r;
        for (int w = 0; w < WORDS; w++) begin
            busy_n_s[w] = (busy_r[w] & ~(wr_en && (wr_idx == SELECT_SIZE'(w))))
                        | (rsv_en && (rsv_idx == SELECT_SIZE'(w)));
        end
    end

    // Pending vector register. Reset clears every bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_n_s;
        end
    end

    // Per-port pending lookup.
    always_comb begin
        pending_s = '0;
        idx_s     = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            idx_s = src_idx[rf_slice_lo(p, SELECT_SIZE) +: SELECT_SIZE];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_idx == idx_s)) begin
                pending_s[p] = rsv_en && (rsv_idx == idx_s);
            end else begin
                pending_s[p] = busy_r[idx_s];
            end
`else
            pending_s[p] = busy_r[idx_s];
`endif
        end
    end

    assign pending = pending_s;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with READ_PORTS combinational read ports, a write-pending
// scoreboard, and a sequencer that zero-fills the bank after reset.
// Optional macro REGFILE_BYPASS_EN: a write in RUN is forwarded to matching read ports in the same cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int WORDS       = RF_WORDS,
    parameter int SELECT_SIZE = $clog2(WORDS),
    parameter int READ_PORTS  = 2,
    parameter int ZERO_REG    = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    regfile_if.slave rf
);
    localparam logic [SELECT_SIZE-1:0] LAST_IDX = SELECT_SIZE'(WORDS - 1);

    rf_state_t                        state_r;
    rf_state_t                        state_n_s;
    logic [SELECT_SIZE-1:0]           counter_r;
    logic [SELECT_SIZE-1:0]           counter_n_s;
    logic                             ready_r;
    logic [DATA_WIDTH-1:0]            bank_r [WORDS];
    logic                             wr_en_s;
    logic                             rsv_en_s;
    logic [READ_PORTS*DATA_WIDTH-1:0] src_s;
    logic [SELECT_SIZE-1:0]           idx_s;

    // Writes and reserves count only in RUN. Index 0 is excluded when it is hardwired.
    assign wr_en_s  = (state_r == RUN) && !rf.reg_we_i &&
                      !((ZERO_REG != 0) && (rf.reg_dst_i == '0));
    assign rsv_en_s = (state_r == RUN) && rf.rsv_i &&
                      !((ZERO_REG != 0) && (rf.reg_rsv_i == '0));

    // Next state: INIT walks the counter up to the last index. RUN then holds.
    always_comb begin
        state_n_s   = state_r;
        counter_n_s = counter_r;
        case (state_r)
            INIT: begin
                counter_n_s = counter_r + SELECT_SIZE'(1);
                if (counter_r == LAST_IDX) begin
                    state_n_s = RUN;
                end else begin
                    state_n_s = INIT;
                end
            end
            RUN: begin
                state_n_s   = RUN;
                counter_n_s = counter_r;
            end
            default: begin
                state_n_s   = INIT;
                counter_n_s = '0;
            end
        endcase
    end

    // State, init counter and ready flag. Reset restarts INIT from index 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= INIT;
            counter_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            counter_r <= counter_n_s;
            ready_r   <= (state_n_s == RUN);
        end
    end

    // Bank write port: zero-fill during INIT, user writes in RUN.
    always_ff @(posedge clk_i) begin
        if (state_r == INIT) begin
            bank_r[counter_r] <= '0;
        end else if (wr_en_s) begin
            bank_r[rf.reg_dst_i] <= rf.data_i;
        end
    end

    // Read multiplexers. Output is zero in INIT and for a hardwired x0.
    always_comb begin
        src_s = '0;
        idx_s = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            idx_s = rf.reg_src_i[rf_slice_lo(p, SELECT_SIZE) +: SELECT_SIZE];
            if (state_r != RUN) begin
                src_s[rf_slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (idx_s == '0)) begin
                src_s[rf_slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en_s && (rf.reg_dst_i == idx_s)) begin
                src_s[rf_slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = rf.data_i;
`endif
            end else begin
                src_s[rf_slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = bank_r[idx_s];
            end
        end
    end

    regfile_scoreboard #(
        .WORDS       (WORDS),
        .SELECT_SIZE (SELECT_SIZE),
        .READ_PORTS  (READ_PORTS)
    ) u_scoreboard (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en_s),
        .wr_idx  (rf.reg_dst_i),
        .rsv_en  (rsv_en_s),
        .rsv_idx (rf.reg_rsv_i),
        .src_idx (rf.reg_src_i),
        .pending (rf.pending_o)
    );

    assign rf.src_o   = src_s;
    assign rf.ready_o = ready_r;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp with 32 x 32-bit registers, 2 ports and ZERO_REG=1.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int WD = 32;
    localparam int SS = 5;
    localparam int RP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_if #(.DATA_WIDTH(DW), .SELECT_SIZE(SS), .READ_PORTS(RP)) bus ();

    regfile_mp #(
        .DATA_WIDTH  (DW),
        .WORDS       (WD),
        .SELECT_SIZE (SS),
        .READ_PORTS  (RP),
        .ZERO_REG    (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [4:0] a, input logic [4:0] b);
        bus.reg_src_i = {b, a};
        #1;
    endtask

    task automatic chk_ready_count(input string tag);
        for (int i = 0; i < WD; i++) begin
            chk({tag, "_ready_low"}, {31'd0, bus.ready_o}, 32'd0);
            step();
        end
        chk({tag, "_ready_high"}, {31'd0, bus.ready_o}, 32'd1);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < WD; i++) begin
            set_src(5'(i), 5'(31 - i));
            chk({tag, "_src0"}, bus.src_o[31:0], 32'd0);
            chk({tag, "_src1"}, bus.src_o[63:32], 32'd0);
            chk({tag, "_pend"}, {30'd0, bus.pending_o}, 32'd0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bus.reg_we_i  = 1'b1;
        bus.reg_dst_i = 5'd0;
        bus.data_i    = 32'd0;
        bus.rsv_i     = 1'b0;
        bus.reg_rsv_i = 5'd0;
        bus.reg_src_i = 10'd0;
        #2;
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_src", bus.src_o[31:0], 32'd0);
        chk("rst_pend", {30'd0, bus.pending_o}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Reset release: exactly 32 cycles of INIT, then all zeros
        chk_ready_count("init1");
        sweep_zero("init1");

        // Write/read x14
        set_src(5'd14, 5'd14);
        bus.reg_we_i  = 1'b0;
        bus.reg_dst_i = 5'd14;
        bus.data_i    = 32'hBEEFDEAD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr14_same_cycle", bus.src_o[31:0], 32'hBEEFDEAD);
`else
        chk("wr14_same_cycle", bus.src_o[31:0], 32'd0);
`endif
        step();
        bus.reg_we_i = 1'b1;
        #1;
        chk("wr14_src0", bus.src_o[31:0], 32'hBEEFDEAD);
        chk("wr14_src1", bus.src_o[63:32], 32'hBEEFDEAD);
        chk("wr14_pend", {30'd0, bus.pending_o}, 32'd0);

        // Zero register: write and reserve x0 are ignored
        bus.reg_we_i  = 1'b0;
        bus.reg_dst_i = 5'd0;
        bus.data_i    = 32'h12345678;
        bus.rsv_i     = 1'b1;
        bus.reg_rsv_i = 5'd0;
        set_src(5'd0, 5'd0);
        chk("x0_same_src", bus.src_o[31:0], 32'd0);
        step();
        bus.reg_we_i = 1'b1;
        bus.rsv_i    = 1'b0;
        #1;
        chk("x0_src0", bus.src_o[31:0], 32'd0);
        chk("x0_src1", bus.src_o[63:32], 32'd0);
        chk("x0_pend", {30'd0, bus.pending_o}, 32'd0);

        // Scoreboard on x5
        set_src(5'd5, 5'd5);
        bus.rsv_i     = 1'b1;
        bus.reg_rsv_i = 5'd5;
        #1;
        chk("sb_before_rsv", {30'd0, bus.pending_o}, 32'd0);
        step();
        bus.rsv_i = 1'b0;
        #1;
        chk("sb_rsv_p0", {31'd0, bus.pending_o[0]}, 32'd1);
        chk("sb_rsv_p1", {31'd0, bus.pending_o[1]}, 32'd1);
        bus.reg_we_i  = 1'b0;
        bus.reg_dst_i = 5'd5;
        bus.data_i    = 32'h00000055;
        bus.rsv_i     = 1'b1;
        bus.reg_rsv_i = 5'd5;
        #1;
        chk("sb_wr_rsv_same", {31'd0, bus.pending_o[0]}, 32'd1);
        step();
        bus.reg_we_i = 1'b1;
        bus.rsv_i    = 1'b0;
        #1;
        chk("sb_wr_rsv_after", {31'd0, bus.pending_o[0]}, 32'd1);
        chk("sb_wr_rsv_data", bus.src_o[31:0], 32'h00000055);
        bus.reg_we_i  = 1'b0;
        bus.reg_dst_i = 5'd5;
        bus.data_i    = 32'h00000066;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb_wr_same", {31'd0, bus.pending_o[0]}, 32'd0);
`else
        chk("sb_wr_same", {31'd0, bus.pending_o[0]}, 32'd1);
`endif
        step();
        bus.reg_we_i = 1'b1;
        #1;
        chk("sb_wr_after", {30'd0, bus.pending_o}, 32'd0);
        chk("sb_wr_data", bus.src_o[63:32], 32'h00000066);

        // Bypass on x7 via port 1
        set_src(5'd14, 5'd7);
        bus.reg_we_i  = 1'b0;
        bus.reg_dst_i = 5'd7;
        bus.data_i    = 32'h11111111;
        step();
        bus.data_i = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", bus.src_o[63:32], 32'hA5A5A5A5);
`else
        chk("byp_same", bus.src_o[63:32], 32'h11111111);
`endif
        chk("byp_other_port", bus.src_o[31:0], 32'hBEEFDEAD);
        step();
        bus.reg_we_i = 1'b1;
        #1;
        chk("byp_next", bus.src_o[63:32], 32'hA5A5A5A5);

        // Reset mid-INIT, then writes/reserves attempted during the new INIT
        rst = 1'b1;
        #1;
        chk("rst2_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst2_src", bus.src_o[31:0], 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_init_ready", {31'd0, bus.ready_o}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < WD; i++) begin
            chk("init2_ready_low", {31'd0, bus.ready_o}, 32'd0);
            bus.reg_we_i  = 1'b0;
            bus.reg_dst_i = 5'(i);
            bus.data_i    = 32'hFFFFFFFF;
            bus.rsv_i     = 1'b1;
            bus.reg_rsv_i = 5'd3;
            step();
        end
        bus.reg_we_i = 1'b1;
        bus.rsv_i    = 1'b0;
        #1;
        chk("init2_ready_high", {31'd0, bus.ready_o}, 32'd1);
        sweep_zero("init2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a write-pending scoreboard and a hardware zero-initialisation sequencer. It is the next-generation operand store for the RV32I datapath: it holds the architectural registers, provides READ_PORTS combinational operands, tracks registers with an outstanding write so that the control unit can stall, and guarantees that every register reads zero after reset without needing preload data.

## Interface
- DATA_WIDTH, 32: register width in bits.
- WORDS, 32: number of registers; must be a power of two, ≥ 2.
- SELECT_SIZE, $clog2(WORDS): width of the register index.
- READ_PORTS, 2: number of independent read ports, 1..4.
- ZERO_REG, 1: 1 hardwires register 0 to zero; 0 makes register 0 an ordinary register.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- reg_we_i  in  1  write enable, active low.
- reg_dst_i  in  SELECT_SIZE  write destination index.
- data_i  in  DATA_WIDTH  write data.
- rsv_i  in  1  active-high reserve strobe; marks reg_rsv_i as write-pending.
- reg_rsv_i  in  SELECT_SIZE  index to reserve.
- reg_src_i  in  READ_PORTS*SELECT_SIZE  packed read indices; port p uses slice p.
- src_o  out  READ_PORTS*DATA_WIDTH  packed read data; port p uses slice p.
- pending_o  out  READ_PORTS  1 when port p's source register has an outstanding write.
- ready_o  out  1  1 once initialisation is complete.

## Operation
- FSM states: INIT and RUN. rst_i asserted forces INIT and clears the index counter to 0 and all scoreboard bits to 0. ready_o=0, src_o=0, and pending_o=0 while in reset.
- INIT: each cycle writes zero to bank[counter] and increments the counter. After writing WORDS-1, the FSM enters RUN. While in INIT, reg_we_i and rsv_i are ignored, ready_o=0, and every src_o slice is forced to 0.
- RUN: ready_o=1. When reg_we_i=0, bank[reg_dst_i] is written with data_i and the scoreboard bit for reg_dst_i is cleared. When rsv_i=1, the scoreboard bit for reg_rsv_i is set.
- Simultaneous write and reserve to the same index: the data is written and the scoreboard bit ends up set, so the reserve wins.
- With ZERO_REG=1: writes and reserves to index 0 are ignored, reads of index 0 return 0, and pending_o for index 0 is always 0.
- Reads are combinational: src_o[p] = bank[reg_src_i[p]], and pending_o[p] = scoreboard[reg_src_i[p]], subject to the bypass rules in Configuration.
- Any number of ports may address the same register; each port gets identical results.
- Reset asserted mid-INIT or mid-RUN restarts INIT from index 0. Bank contents are not otherwise touched until rewritten.

## Timing
- Write latency: the data is visible on a non-bypassed read in the cycle after the rising edge on which reg_we_i=0 is sampled.
- Reserve latency: pending_o rises in the cycle after rsv_i is sampled.
- Initialisation takes exactly WORDS cycles from the first rising edge after rst_i deasserts. ready_o rises on the edge that writes index WORDS-1.
- The counter is SELECT_SIZE bits. It does not wrap back into INIT; the terminal-count compare uses WORDS-1.

## Configuration
- REGFILE_BYPASS_EN defined: when the FSM is in RUN, reg_we_i=0, and reg_dst_i equals reg_src_i[p] (non-zero when ZERO_REG=1):
  - src_o[p] returns data_i in the same cycle.
  - pending_o[p] reads 0 in the same cycle, unless rsv_i=1 with reg_rsv_i equal to that same index.
- REGFILE_BYPASS_EN undefined: reads return stored bank contents only, and pending_o reflects only the registered scoreboard. The write is observed one cycle later.

## Structure
- Package regfile_pkg holds:
  - the state enum rf_state_t (INIT, RUN);
  - the default width constants RF_DATA_WIDTH=32 and RF_WORDS=32;
  - the function rf_slice_lo for computing packed-port offsets.
- Sub-module regfile_scoreboard holds the WORDS-bit pending vector, its set/clear logic, and the per-port pending lookup including the bypass term. The bank, FSM and read multiplexing stay in regfile_mp.

## Test plan
- Reset release: pulse rst_i, then clock 32 cycles. Required: ready_o=0 for exactly 32 cycles, then 1; all ports read 0 for indices 0..31.
- Write/read: in RUN, write 32'hBEEFDEAD to x14, then read x14 on both ports the next cycle. Required: both ports return BEEFDEAD, and pending_o=0.
- Zero register: write 32'h12345678 to x0 and reserve x0. Required: x0 reads 0 and pending_o=0.
- Scoreboard: reserve x5; pending_o[0]=1 with src0=x5. Next cycle, write x5 and reserve x5 together. Required: pending_o stays 1. Then write x5 alone. Required: pending_o=0 the next cycle.
- Bypass: write 32'hA5A5A5A5 to x7 while src1=x7. With REGFILE_BYPASS_EN, src_o[1]=A5A5A5A5 in the same cycle. Without it, the old value is returned that cycle and A5A5A5A5 the next.
- Reset mid-INIT: assert rst_i at cycle 10 of INIT, release it, and attempt writes during the new INIT. Required: a full 32-cycle INIT again, writes ignored, and all registers 0 afterward.
